segway_math_pipe: RTL

//  Parametrised, pipelined successor to the combinational segway math stage.

---
 rtl/segway_math_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/segway_math_pipe.sv
// Two-stage segway wheel-speed pipeline: soft-start scaled PID plus clipped steering, saturated to W bits, with persistent overspeed flag.
// vld_in -> vld_out in 2 clks, full throughput, no backpressure; define SPD_SLEW_EN to rate-limit speed changes per valid sample.
module segway_math_pipe #(
  parameter int          W            = 12,
  parameter int          SS_BITS      = 8,
  parameter int          SS_PRE       = 0,
  parameter logic [11:0] STEER_MIN    = 12'h200,
  parameter logic [11:0] STEER_MAX    = 12'hE00,
  parameter int          FAST_THRESH  = 1536,
  parameter int          FAST_PERSIST = 4,
  parameter int          SLEW_STEP    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld_in,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic        [11:0]  steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic                vld_out,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                too_fast,
  output logic                ss_done
);

  localparam int PW  = SS_PRE + 1;
  localparam int PW1 = W + SS_BITS + 1;
  localparam int SW  = W + 2;
  localparam int SPW = W + 6;
  localparam int CW  = $clog2(FAST_PERSIST + 1);

  localparam logic        [PW-1:0] PRE_LAST = PW'((1 << SS_PRE) - 1);
  localparam logic signed [SW-1:0] SMAX     = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN     = SW'(-(2 ** (W - 1)));
  localparam logic signed [SW-1:0] FAST_T   = SW'(FAST_THRESH);
  localparam logic        [CW-1:0] FP_C     = CW'(FAST_PERSIST);

  // ---------------- soft-start ramp ----------------
  logic [PW-1:0]      pre_cnt;
  logic [SS_BITS-1:0] ss_tmr;
  logic               pre_wrap;

  assign pre_wrap = (pre_cnt == PRE_LAST);
  assign ss_done  = &ss_tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      ss_tmr  <= '0;
    end else if (!pwr_up) begin
      pre_cnt <= '0;
      ss_tmr  <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      if (pre_wrap && !ss_done)
        ss_tmr <= ss_tmr + 1'b1;
    end
  end

  // ---------------- stage 1: scale and steer ----------------
  logic signed [PW1-1:0] prod;
  logic        [11:0]    pot_clip;
  logic signed [12:0]    sp;
  logic signed [SPW-1:0] sp3;
  logic                  unused_bits;

  always_comb begin
    prod     = PW1'(PID_cntrl) * PW1'($signed({1'b0, ss_tmr}));
    pot_clip = (steer_pot < STEER_MIN) ? STEER_MIN :
               (steer_pot > STEER_MAX) ? STEER_MAX : steer_pot;
    sp       = $signed({1'b0, pot_clip}) - 13'sh7FF;
    sp3      = SPW'(sp) * SPW'(3);
  end

  // Bit slices below are the arithmetic shifts (>>> SS_BITS, >>> 4), so both floor.
  assign unused_bits = ^{prod[SS_BITS-1:0], prod[PW1-1], sp3[3:0]};

  logic                 v1;
  logic signed [W-1:0]  pid_ss_r;
  logic signed [SW-1:0] steer_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      pid_ss_r <= '0;
      steer_r  <= '0;
    end else begin
      v1 <= vld_in;
      if (vld_in) begin
        pid_ss_r <= prod[SS_BITS +: W];
        steer_r  <= en_steer ? sp3[SW+3:4] : '0;
      end
    end
  end

  // ---------------- stage 2: sum, saturate, overspeed ----------------
  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SMAX)      sat = SMAX[W-1:0];
    else if (x < SMIN) sat = SMIN[W-1:0];
    else               sat = x[W-1:0];
  endfunction

`ifdef SPD_SLEW_EN
  localparam logic signed [SW-1:0] STEP = SW'(SLEW_STEP);

  function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] prev,
                                               input logic signed [W-1:0] tgt);
    logic signed [SW-1:0] p;
    logic signed [SW-1:0] d;
    p = SW'(prev);
    d = SW'(tgt) - p;
    if (d > STEP)       slew = sat(p + STEP);
    else if (d < -STEP) slew = sat(p - STEP);
    else                slew = tgt;
  endfunction
`endif

  logic signed [SW-1:0] pid_ext, sum_l, sum_r, lft_ext, rght_ext;
  logic signed [W-1:0]  lft_n, rght_n;
  logic                 is_fast;
  logic        [CW-1:0] fast_cnt, cnt_n;

  always_comb begin
    pid_ext = SW'(pid_ss_r);
    sum_l   = pid_ext + steer_r;
    sum_r   = pid_ext - steer_r;
    lft_n   = sat(sum_l);
    rght_n  = sat(sum_r);
`ifdef SPD_SLEW_EN
    lft_n   = slew(lft_spd, lft_n);
    rght_n  = slew(rght_spd, rght_n);
`endif
    lft_ext  = SW'(lft_n);
    rght_ext = SW'(rght_n);
    is_fast  = (lft_ext > FAST_T) || (rght_ext > FAST_T);
    cnt_n    = !is_fast ? '0 : (fast_cnt == FP_C) ? fast_cnt : fast_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out  <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
      fast_cnt <= '0;
      too_fast <= 1'b0;
    end else begin
      vld_out <= v1;
      // Rider off: drive is forced to zero regardless of pipeline contents.
      if (!pwr_up) begin
        lft_spd  <= '0;
        rght_spd <= '0;
        fast_cnt <= '0;
        too_fast <= 1'b0;
      end else if (v1) begin
        lft_spd  <= lft_n;
        rght_spd <= rght_n;
        fast_cnt <= cnt_n;
        too_fast <= (cnt_n == FP_C);
      end
    end
  end

endmodule
